// File: rtl/dpi_regex_ctx_engine_if.sv
// Packet-side handshake between the DPI core and the regex context engine.
interface dpi_regex_ctx_engine_if #(
    parameter int SID_W = 6
) ();
    logic             sop_load;
    logic [SID_W-1:0] stream_id;
    logic             new_stream_id;
    logic             enable;
    logic [7:0]       char_in;
    logic             char_in_vld;
    logic             eop;
    logic             abort;
    logic             ready;
    logic             busy;

    modport master (
        output sop_load, stream_id, new_stream_id, enable,
        output char_in, char_in_vld, eop, abort,
        input  ready, busy
    );

    modport slave (
        input  sop_load, stream_id, new_stream_id, enable,
        input  char_in, char_in_vld, eop, abort,
        output ready, busy
    );
endinterface

// File: rtl/dpi_regex_ctx_engine.sv
// Per-stream DFA context save/restore around one external regex matcher,
// with per-packet match flag and committed match counter.
module dpi_regex_ctx_engine #(
    parameter int STATE_W   = 11,
    parameter int SID_W     = 6,
    parameter int COUNT_W   = 16,
    parameter bit COUNT_SAT = 1'b1,
    parameter int DFA_LAT   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    dpi_regex_ctx_engine_if.slave pkt,
    input  logic               clear_count,
    output logic [7:0]         dfa_char,
    output logic               dfa_char_vld,
    output logic [STATE_W-1:0] dfa_state_in,
    output logic               dfa_state_in_vld,
    input  logic [STATE_W-1:0] dfa_state_out,
    input  logic               dfa_accept,
    output logic               fired,
    output logic [COUNT_W-1:0] count,
    output logic               commit_done
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, COMMIT} state_t;

    localparam int DEPTH = 2 ** SID_W;

    state_t             state;
    state_t             state_nx;
    logic [SID_W-1:0]   sid;
    logic               en;
    logic               init;
    logic [DEPTH-1:0]   valid;
    logic [STATE_W-1:0] mem [DEPTH];
    logic [STATE_W-1:0] last_state;
    logic [2:0]         drain_cnt;
    logic [2:0]         res_pipe;
    logic               res_vld;
    logic               kill;
    logic               active;
    logic               commit_en;

    assign kill      = pkt.abort && (state inside {LOAD, RUN, DRAIN});
    assign active    = (state == RUN) || (state == DRAIN);
    assign commit_en = (state == COMMIT) && en;

    // DFA result is valid DFA_LAT cycles after the char strobe
    always_comb begin
        res_vld = dfa_char_vld;
        for (int i = 1; i <= 3; i++)
            if (i == DFA_LAT) res_vld = res_pipe[i-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (pkt.sop_load) state_nx = LOAD;
            LOAD:    state_nx = RUN;
            RUN:     if (pkt.eop) state_nx = DRAIN;
            DRAIN:   if (drain_cnt == 3'd0) state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (kill) state_nx = IDLE;
    end

    always_comb begin
        pkt.ready = (state == RUN);
        pkt.busy  = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sid              <= '0;
            en               <= 1'b0;
            init             <= 1'b0;
            valid            <= '0;
            dfa_char         <= '0;
            dfa_char_vld     <= 1'b0;
            dfa_state_in     <= '0;
            dfa_state_in_vld <= 1'b0;
            res_pipe         <= '0;
            last_state       <= '0;
            drain_cnt        <= '0;
            fired            <= 1'b0;
            commit_done      <= 1'b0;
        end else begin
            dfa_char         <= pkt.char_in;
            dfa_char_vld     <= pkt.ready && pkt.char_in_vld && !pkt.abort;
            dfa_state_in_vld <= (state == LOAD) && !pkt.abort;
            commit_done      <= (state == COMMIT);
            res_pipe         <= kill ? 3'd0 : {res_pipe[1:0], dfa_char_vld};

            if (state == IDLE && pkt.sop_load) begin
                sid  <= pkt.stream_id;
                en   <= pkt.enable;
                init <= pkt.new_stream_id | ~valid[pkt.stream_id];
            end

            // restored state doubles as the commit value of an empty packet
            if (state == LOAD) begin
                dfa_state_in <= init ? '0 : mem[sid];
                last_state   <= init ? '0 : mem[sid];
            end else if (active && res_vld && !kill) begin
                last_state <= dfa_state_out;
            end

            if (state == RUN && pkt.eop)
                drain_cnt <= 3'(DFA_LAT + 1);
            else if (state == DRAIN && drain_cnt != 3'd0)
                drain_cnt <= drain_cnt - 3'd1;

            if (kill || state == LOAD || (state == COMMIT && !en))
                fired <= 1'b0;
            else if (active && res_vld && dfa_accept)
                fired <= 1'b1;

            if (commit_en) valid[sid] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && commit_en) mem[sid] <= last_state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            count <= '0;
        else if (clear_count)
            count <= (commit_en && fired) ? COUNT_W'(1) : '0;
        else if (commit_en && fired && (!COUNT_SAT || count != '1))
            count <= count + COUNT_W'(1);
    end
endmodule

// File: tb/tb_dpi_regex_ctx_engine.sv
// Directed bench: three engines (16b sat, 2b sat, 2b wrap) share one stimulus
// and each drives its own small "ab" DFA with one cycle of latency.
module tb_dpi_regex_ctx_engine;
    logic       clk;
    logic       rst_n;
    logic       sop_load;
    logic [5:0] stream_id;
    logic       new_stream_id;
    logic       enable;
    logic [7:0] char_in;
    logic       char_in_vld;
    logic       eop;
    logic       abort;
    logic       clear_count;

    logic        rdy  [3];
    logic        bsy  [3];
    logic        fir  [3];
    logic        cd   [3];
    logic        cv   [3];
    logic [7:0]  dch  [3];
    logic [10:0] sin  [3];
    logic        sinv [3];
    logic [15:0] cnt  [3];

    int ntest = 0;
    int nfail = 0;

    function automatic logic [10:0] nxt(input logic [10:0] s, input logic [7:0] c);
        if (c == 8'h61) return 11'd1;
        if (c == 8'h62 && s == 11'd1) return 11'd2;
        return 11'd0;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int CW  = (g == 0) ? 16 : 2;
        localparam bit SAT = (g == 2) ? 1'b0 : 1'b1;

        dpi_regex_ctx_engine_if #(.SID_W(6)) pif ();
        logic [CW-1:0] c;
        logic [10:0]   st;

        assign pif.sop_load      = sop_load;
        assign pif.stream_id     = stream_id;
        assign pif.new_stream_id = new_stream_id;
        assign pif.enable        = enable;
        assign pif.char_in       = char_in;
        assign pif.char_in_vld   = char_in_vld;
        assign pif.eop           = eop;
        assign pif.abort         = abort;
        assign rdy[g]            = pif.ready;
        assign bsy[g]            = pif.busy;
        assign cnt[g]            = 16'(c);

        dpi_regex_ctx_engine #(
            .STATE_W(11), .SID_W(6), .COUNT_W(CW),
            .COUNT_SAT(SAT), .DFA_LAT(1)
        ) dut (
            .clk(clk),
            .rst_n(rst_n),
            .pkt(pif),
            .clear_count(clear_count),
            .dfa_char(dch[g]),
            .dfa_char_vld(cv[g]),
            .dfa_state_in(sin[g]),
            .dfa_state_in_vld(sinv[g]),
            .dfa_state_out(st),
            .dfa_accept(st == 11'd2),
            .fired(fir[g]),
            .count(c),
            .commit_done(cd[g])
        );

        always @(posedge clk) begin
            if (!rst_n)       st <= '0;
            else if (sinv[g]) st <= sin[g];
            else if (cv[g])   st <= nxt(st, dch[g]);
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntest++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkc(input string tag, input int e0, input int e1, input int e2);
        chk({tag, "_c16"}, 32'(cnt[0]), e0);
        chk({tag, "_sat2"}, 32'(cnt[1]), e1);
        chk({tag, "_wrap2"}, 32'(cnt[2]), e2);
    endtask

    // sop in IDLE; returns in the first RUN cycle
    task automatic start(input logic [5:0] s, input logic nw, input logic e);
        sop_load = 1'b1;
        stream_id = s;
        new_stream_id = nw;
        enable = e;
        tick;
        sop_load = 1'b0;
        tick;
    endtask

    task automatic body(input logic [7:0] b [$], input logic with_eop);
        foreach (b[i]) begin
            char_in = b[i];
            char_in_vld = 1'b1;
            eop = with_eop && (i == b.size() - 1);
            tick;
        end
        char_in_vld = 1'b0;
        eop = 1'b0;
    endtask

    task automatic match_pkt;
        start(6'd3, 1'b1, 1'b1);
        body('{8'h61, 8'h62}, 1'b1);
        repeat (4) tick;
    endtask

    initial begin
        rst_n = 1'b0;
        sop_load = 1'b0;
        stream_id = '0;
        new_stream_id = 1'b0;
        enable = 1'b0;
        char_in = '0;
        char_in_vld = 1'b0;
        eop = 1'b0;
        abort = 1'b0;
        clear_count = 1'b0;
        repeat (3) tick;
        chk("rst_ready", 32'(rdy[0]), 0);
        chk("rst_busy", 32'(bsy[0]), 0);
        chk("rst_fired", 32'(fir[0]), 0);
        chk("rst_cdone", 32'(cd[0]), 0);
        chk("rst_cvld", 32'(cv[0]), 0);
        chk("rst_sinv", 32'(sinv[0]), 0);
        chkc("rst_count", 0, 0, 0);
        rst_n = 1'b1;
        tick;

        start(6'd5, 1'b1, 1'b1);
        chk("p1_sin", 32'(sin[0]), 0);
        chk("p1_sinv", 32'(sinv[0]), 1);
        chk("p1_ready", 32'(rdy[0]), 1);
        chk("p1_busy", 32'(bsy[0]), 1);
        body('{8'h78, 8'h61}, 1'b1);
        chk("p1_dchar", 32'(dch[0]), 32'h61);
        chk("p1_dvld", 32'(cv[0]), 1);
        chk("p1_drain_ready", 32'(rdy[0]), 0);
        repeat (4) tick;
        chk("p1_cdone", 32'(cd[0]), 1);
        chk("p1_fired", 32'(fir[0]), 0);
        chkc("p1_count", 0, 0, 0);
        tick;
        chk("p1_cdone_pulse", 32'(cd[0]), 0);
        chk("p1_idle_busy", 32'(bsy[0]), 0);

        start(6'd5, 1'b0, 1'b1);
        chk("p2_sin_saved", 32'(sin[0]), 1);
        body('{8'h62, 8'h7a}, 1'b1);
        repeat (4) tick;
        chk("p2_cdone", 32'(cd[0]), 1);
        chk("p2_fired", 32'(fir[0]), 1);
        chkc("p2_count", 1, 1, 1);

        start(6'd7, 1'b1, 1'b1);
        body('{8'h61, 8'h62}, 1'b1);
        repeat (2) tick;
        chk("p3_fired_drain", 32'(fir[0]), 1);
        chk("p3_count_pre", 32'(cnt[0]), 1);
        repeat (2) tick;
        chk("p3_cdone", 32'(cd[0]), 1);
        chkc("p3_count", 2, 2, 2);

        start(6'd7, 1'b0, 1'b0);
        chk("p4_sin", 32'(sin[0]), 2);
        body('{8'h61, 8'h62, 8'h7a}, 1'b1);
        repeat (2) tick;
        chk("p4_fired_run", 32'(fir[0]), 1);
        repeat (2) tick;
        chk("p4_cdone", 32'(cd[0]), 1);
        chk("p4_fired_clr", 32'(fir[0]), 0);
        chkc("p4_count", 2, 2, 2);

        start(6'd7, 1'b0, 1'b1);
        chk("p5_mem_kept", 32'(sin[0]), 2);
        body('{8'h71}, 1'b1);
        repeat (4) tick;
        chk("p5_fired", 32'(fir[0]), 0);
        chkc("p5_count", 2, 2, 2);

        start(6'd9, 1'b0, 1'b1);
        chk("p6_sin_init", 32'(sin[0]), 0);
        body('{8'h61, 8'h62}, 1'b0);
        repeat (2) tick;
        chk("p6_fired_run", 32'(fir[0]), 1);
        abort = 1'b1;
        char_in = 8'h61;
        char_in_vld = 1'b1;
        tick;
        abort = 1'b0;
        char_in_vld = 1'b0;
        chk("p6_abort_busy", 32'(bsy[0]), 0);
        chk("p6_abort_fired", 32'(fir[0]), 0);
        chk("p6_abort_cvld", 32'(cv[0]), 0);
        repeat (4) begin
            chk("p6_no_cdone", 32'(cd[0]), 0);
            tick;
        end
        chkc("p6_count", 2, 2, 2);

        start(6'd9, 1'b0, 1'b1);
        chk("p7_sin_novalid", 32'(sin[0]), 0);
        body('{8'h61}, 1'b1);
        repeat (4) tick;
        chk("p7_cdone", 32'(cd[0]), 1);

        clear_count = 1'b1;
        tick;
        clear_count = 1'b0;
        chkc("clr_idle", 0, 0, 0);

        repeat (5) match_pkt;
        chkc("five_match", 5, 3, 1);
        repeat (2) match_pkt;
        chkc("seven_match", 7, 3, 3);

        start(6'd3, 1'b0, 1'b1);
        body('{8'h61, 8'h62}, 1'b1);
        repeat (3) tick;
        clear_count = 1'b1;
        tick;
        clear_count = 1'b0;
        chk("clr_commit_cdone", 32'(cd[0]), 1);
        chkc("clr_commit", 1, 1, 1);

        start(6'd3, 1'b0, 1'b1);
        chk("pr_sin_saved", 32'(sin[0]), 2);
        body('{8'h61, 8'h62}, 1'b0);
        repeat (2) tick;
        chk("pr_fired_run", 32'(fir[0]), 1);
        rst_n = 1'b0;
        tick;
        chk("pr_ready", 32'(rdy[0]), 0);
        chk("pr_busy", 32'(bsy[0]), 0);
        chk("pr_fired", 32'(fir[0]), 0);
        chk("pr_cdone", 32'(cd[0]), 0);
        chk("pr_cvld", 32'(cv[0]), 0);
        chk("pr_sinv", 32'(sinv[0]), 0);
        chkc("pr_count", 0, 0, 0);
        rst_n = 1'b1;
        tick;
        start(6'd3, 1'b0, 1'b1);
        chk("pr_bitmap_clr", 32'(sin[0]), 0);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        tick;

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule

// File: doc/dpi_regex_ctx_engine.md
Name: dpi_regex_ctx_engine

Overview:
- Parametrised per-stream context wrapper for one DFA regex matcher in the DPI packet-inspection core.
- Saves and restores DFA state per stream ID across packets, so matches can span packets of the same stream.
- Flags a per-packet match and keeps a saturating or wrapping match count.
- The DFA is external: the block drives and samples it through registered ports, so any generated matcher of any state width can attach. A drain phase guarantees the last character's result is committed before EOP bookkeeping.

Parameters:
- STATE_W, 11, DFA state width.
- SID_W, 6, stream-ID width; context memory depth = 2**SID_W.
- COUNT_W, 16, match counter width.
- COUNT_SAT, 1, 1 = counter saturates at all-ones; 0 = counter wraps.
- DFA_LAT, 1, cycles from dfa_char_vld to valid dfa_state_out/dfa_accept (0..3).

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, reset: synchronous, active-low.
- sop_load, in, 1, start of packet: load the context for stream_id.
- stream_id, in, SID_W, stream of the packet; sampled with sop_load.
- new_stream_id, in, 1, force initial state 0; sampled with sop_load.
- enable, in, 1, regex enabled for this stream; sampled with sop_load.
- char_in, in, 8, payload byte.
- char_in_vld, in, 1, byte valid; accepted only when ready=1.
- eop, in, 1, end of packet; accepted only in RUN. May coincide with the last char.
- abort, in, 1, discard the current packet without commit.
- clear_count, in, 1, zero count.
- ready, out, 1, 1 in RUN only.
- busy, out, 1, 1 when not IDLE.
- dfa_char, out, 8, registered char_in.
- dfa_char_vld, out, 1, registered accepted char_in_vld.
- dfa_state_in, out, STATE_W, restored state.
- dfa_state_in_vld, out, 1, one-cycle state-load pulse.
- dfa_state_out, in, STATE_W, DFA current state.
- dfa_accept, in, 1, DFA accept.
- fired, out, 1, match seen in the current or most recently committed packet.
- count, out, COUNT_W, committed packets-with-match count.
- commit_done, out, 1, one-cycle pulse after the COMMIT cycle.

Behaviour:
- Reset values:
  - FSM = IDLE.
  - count, fired, ready, dfa_char_vld, dfa_state_in_vld, commit_done = 0.
  - The per-stream valid bitmap (2**SID_W bits) is cleared.
  - State memory contents are not reset.
  - Reset mid-packet discards that packet entirely.
- FSM states: IDLE, LOAD, RUN, DRAIN, COMMIT.
- IDLE:
  - sop_load -> LOAD.
  - Latch sid, en, and init = new_stream_id | ~valid[stream_id].
- LOAD (1 cycle):
  - Registered memory read.
  - Clear fired.
  - Next cycle: dfa_state_in = init ? 0 : mem[sid], dfa_state_in_vld = 1; FSM enters RUN in that same cycle.
- RUN:
  - Each char_in_vld is registered to dfa_char/dfa_char_vld one cycle later.
  - eop -> DRAIN, drain counter = DFA_LAT+1. A char with eop in the same cycle is processed.
  - char_in_vld without ready is dropped.
  - sop_load outside IDLE is ignored.
- DFA result capture: dfa_accept and dfa_state_out are registered every cycle in which the DFA result is valid (DFA_LAT after dfa_char_vld).
  - Any registered accept sets fired (sticky until the next LOAD).
  - The last valid state is held in last_state.
- DRAIN: count down to 0, then COMMIT.
- COMMIT (1 cycle):
  - If en:
    - mem[sid] <= last_state.
    - valid[sid] <= 1.
    - count <= count + fired (saturate/wrap per COUNT_SAT).
  - If ~en: no memory write, no count change, fired cleared.
  - Next cycle: commit_done = 1, FSM = IDLE.
  - A packet with zero chars commits the restored state unchanged.
- abort in LOAD/RUN/DRAIN:
  - Next state IDLE; no commit; fired cleared.
  - dfa_char_vld forced 0 from the next cycle.
  - Late DFA results from the aborted packet are ignored.
- clear_count:
  - In any state, count <= 0.
  - If clear_count coincides with a COMMIT increment, count <= fired (clear first, then add).
- Minimum packet turnaround: sop_load to the next accepted sop_load = 4 + DFA_LAT + 1 + N_chars cycles.

Test Plan:
- New stream 5, en=1, bytes matching only across two packets, DFA_LAT=1: packet 1 -> fired=0, count=0, commit_done pulse. Packet 2 with new_stream_id=0 -> dfa_state_in = saved state, fired=1, count=1.
- Match on the final byte, delivered together with eop: fired=1 after drain, and count increments by exactly 1 at COMMIT.
- en=0 packet containing a match: fired pulses during RUN, clears at COMMIT, count unchanged, mem[sid] unchanged on the next load.
- COUNT_W=2, COUNT_SAT=1: five matching packets -> count = 3. With COUNT_SAT=0 -> count = 1.
- abort mid-RUN after a match: no commit_done, count unchanged, valid[sid] stays 0, next load gives dfa_state_in = 0.
- clear_count asserted in the COMMIT cycle of a matching packet with count=7 -> count = 1. rst_n low mid-packet -> all outputs 0 and the bitmap cleared.
